// File: rtl/leg_pkg.sv
// Shared types for the decode/issue stage: opcode encoding, instruction layout
// and issue-slot state.
package leg_pkg;

  localparam int INSTR_W       = 16;
  localparam int DEPTH_DEFAULT = 2;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_OUT = 4'hB,
    OP_ADD = 4'hD,
    OP_LD  = 4'hF
  } opcode_t;

  typedef struct packed {
    opcode_t    opcode;
    logic [5:0] operand1;
    logic [5:0] operand2;
  } instr_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic logic is_legal(opcode_t op);
    case (op)
      OP_NOP, OP_OUT, OP_ADD, OP_LD: is_legal = 1'b1;
      default:                       is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_issue_sync_fifo.sv
// Small synchronous FIFO with flush; head data is presented combinationally
// from the storage array.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge i_clk) begin
    if (i_rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)
        count <= count + (PW+1)'(1);
      else if (do_pop && !do_push)
        count <= count - (PW+1)'(1);
    end
  end

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/decode_issue.sv
// Decode stage: buffers fetched words, decodes them and presents one
// instruction at a time on a registered issue slot sampled by execute.
//
//   state      | meaning
//   SLOT_EMPTY | slot outputs are a NOP bubble, may load any edge
//   SLOT_FULL  | slot holds a decoded instruction until execute advances
module decode_issue
  import leg_pkg::*;
#(
  parameter int INSTR_WIDTH = INSTR_W,
  parameter int FIFO_DEPTH  = DEPTH_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic                   i_instr_valid,
  output logic                   o_instr_ready,
  input  logic                   i_flush,
  input  logic                   i_stall,
  input  logic                   i_mult_cycle,
  output logic [3:0]             o_opcode,
  output logic [5:0]             o_operand1,
  output logic [5:0]             o_operand2,
  output logic                   o_illegal,
  output logic [15:0]            o_issued
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  slot_state_t            state_q;
  instr_t                 slot_q;
  instr_t                 next_instr;
  logic [INSTR_WIDTH-1:0] head_word;
  logic [INSTR_WIDTH-1:0] load_word;
  logic [CW-1:0]          fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   advance;
  logic                   can_load;
  logic                   push_req;
  logic                   bypass;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   load;
  logic                   load_legal;

  assign advance       = !i_stall && !i_mult_cycle;
  assign can_load      = (state_q == SLOT_EMPTY) || advance;
  assign o_instr_ready = (fifo_count < CW'(FIFO_DEPTH));
  assign push_req      = i_instr_valid && o_instr_ready && !i_flush;

  // Queue head always wins the slot; the incoming word only bypasses when
  // nothing older is waiting, which keeps issue order intact.
  assign fifo_pop   = can_load && !fifo_empty && !i_flush;
  assign bypass     = can_load && fifo_empty && push_req;
  assign fifo_push  = push_req && !bypass && !fifo_full;
  assign load       = fifo_pop || bypass;
  assign load_word  = fifo_empty ? i_instr : head_word;
  assign next_instr = instr_t'(load_word);
  assign load_legal = is_legal(next_instr.opcode);

  sync_fifo #(
    .WIDTH (INSTR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (i_flush),
    .din   (i_instr),
    .head  (head_word),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= SLOT_EMPTY;
      slot_q    <= instr_t'('0);
      o_illegal <= 1'b0;
      o_issued  <= '0;
    end else begin
      if (advance && state_q == SLOT_FULL && slot_q.opcode != OP_NOP)
        o_issued <= o_issued + 16'd1;

      if (i_flush) begin
        state_q   <= SLOT_EMPTY;
        slot_q    <= instr_t'('0);
        o_illegal <= 1'b0;
      end else if (load) begin
        state_q   <= SLOT_FULL;
        slot_q    <= load_legal ? next_instr : instr_t'('0);
        o_illegal <= !load_legal;
      end else begin
        o_illegal <= 1'b0;
        if (advance) begin
          state_q <= SLOT_EMPTY;
          slot_q  <= instr_t'('0);
        end
      end
    end
  end

  assign o_opcode   = slot_q.opcode;
  assign o_operand1 = slot_q.operand1;
  assign o_operand2 = slot_q.operand2;

endmodule

// File: tb/tb_decode_issue.sv
// Randomized and directed bench for decode_issue, checked every cycle against
// a list-based model of the words in flight.
module tb_decode_issue;

  localparam int DEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_instr;
  logic        i_instr_valid;
  logic        o_instr_ready;
  logic        i_flush;
  logic        i_stall;
  logic        i_mult_cycle;
  logic [3:0]  o_opcode;
  logic [5:0]  o_operand1;
  logic [5:0]  o_operand2;
  logic        o_illegal;
  logic [15:0] o_issued;

  always #5 i_clk = ~i_clk;

  decode_issue #(.INSTR_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_instr       (i_instr),
    .i_instr_valid (i_instr_valid),
    .o_instr_ready (o_instr_ready),
    .i_flush       (i_flush),
    .i_stall       (i_stall),
    .i_mult_cycle  (i_mult_cycle),
    .o_opcode      (o_opcode),
    .o_operand1    (o_operand1),
    .o_operand2    (o_operand2),
    .o_illegal     (o_illegal),
    .o_issued      (o_issued)
  );

  // Words in flight, oldest first; the oldest one is what the slot shows.
  typedef struct {
    int          id;
    logic [15:0] word;
    bit          ill;
  } ent_t;

  ent_t        pipe[$];
  int          next_id    = 0;
  int          n_cmp      = 0;
  int          n_fail     = 0;
  bit          mon_en     = 1'b0;
  logic [15:0] exp_issued = '0;
  bit          exp_illegal = 1'b0;

  function automatic bit legal_op(logic [3:0] op);
    return op == 4'h0 || op == 4'hB || op == 4'hD || op == 4'hF;
  endfunction

  function automatic int queued();
    return pipe.size() > 0 ? pipe.size() - 1 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model update at each edge.
  always @(posedge i_clk) begin
    int   old_id;
    bit   rdy;
    ent_t e;
    old_id = pipe.size() > 0 ? pipe[0].id : -1;
    rdy    = queued() < DEPTH;
    if (i_rst) begin
      pipe.delete();
      exp_issued  = '0;
      exp_illegal = 1'b0;
    end else begin
      if (!i_stall && !i_mult_cycle && pipe.size() > 0) begin
        e = pipe.pop_front();
        if (e.word[15:12] != 4'h0) exp_issued = exp_issued + 16'd1;
      end
      if (i_flush) begin
        pipe.delete();
      end else if (i_instr_valid && rdy) begin
        e.id   = next_id;
        next_id++;
        e.ill  = !legal_op(i_instr[15:12]);
        e.word = e.ill ? 16'h0000 : i_instr;
        pipe.push_back(e);
      end
      exp_illegal = pipe.size() > 0 && pipe[0].id != old_id && pipe[0].ill;
    end
  end

  // Monitor: compares all outputs shortly after every edge.
  always begin
    logic [15:0] exp_slot;
    @(posedge i_clk);
    #1;
    if (mon_en) begin
      exp_slot = pipe.size() > 0 ? pipe[0].word : 16'h0000;
      check("slot", 32'({o_opcode, o_operand1, o_operand2}), 32'(exp_slot));
      check("ready", 32'(o_instr_ready), 32'(queued() < DEPTH));
      check("illegal", 32'(o_illegal), 32'(exp_illegal));
      check("issued", 32'(o_issued), 32'(exp_issued));
    end
  end

  task automatic cyc(input bit v, input logic [15:0] w, input bit st, input bit mc,
                     input bit fl, input bit rs);
    i_instr_valid = v;
    i_instr       = w;
    i_stall       = st;
    i_mult_cycle  = mc;
    i_flush       = fl;
    i_rst         = rs;
    @(negedge i_clk);
  endtask

  initial begin
    logic [15:0] iss;
    logic [15:0] w;
    logic [3:0]  op;
    bit          acc;
    int          k;

    i_rst = 1'b1; i_instr = '0; i_instr_valid = 1'b0;
    i_flush = 1'b0; i_stall = 1'b0; i_mult_cycle = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_slot", 32'({o_opcode, o_operand1, o_operand2}), 32'h0);
    check("rst_ready", 32'(o_instr_ready), 32'h1);
    check("rst_illegal", 32'(o_illegal), 32'h0);
    check("rst_issued", 32'(o_issued), 32'h0);
    mon_en = 1'b1;

    // single word, one-edge latency
    cyc(1, 16'hF085, 0, 0, 0, 0);
    check("t2_fields", 32'({o_opcode, o_operand1, o_operand2}), 32'({4'hF, 6'd2, 6'd5}));
    cyc(0, 16'h0000, 0, 0, 0, 0);
    check("t2_issued", 32'(o_issued), 32'h1);

    // back-pressure from multi-cycle execute
    cyc(1, 16'hD085, 0, 0, 0, 0);
    cyc(1, 16'hB041, 0, 1, 0, 0);
    cyc(1, 16'hD0C3, 0, 1, 0, 0);
    check("t3_ready_full", 32'(o_instr_ready), 32'h0);
    cyc(1, 16'hF105, 0, 1, 0, 0);
    check("t3_slot_hold", 32'({o_opcode, o_operand1, o_operand2}), 32'h0000D085);
    k = 0;
    do begin
      acc = o_instr_ready;
      cyc(1, 16'hF105, 0, 0, 0, 0);
      if (k == 0) check("t3_next_in_order", 32'({o_opcode, o_operand1, o_operand2}), 32'h0000B041);
      k++;
    end while (!acc && k < 10);
    check("t3_accept_bound", 32'(acc), 32'h1);
    repeat (4) cyc(0, 16'h0000, 0, 0, 0, 0);

    // flush with full queue and full slot
    cyc(1, 16'hD085, 0, 1, 0, 0);
    cyc(1, 16'hB041, 0, 1, 0, 0);
    cyc(1, 16'hD0C3, 0, 1, 0, 0);
    iss = o_issued;
    cyc(1, 16'hF0FF, 0, 1, 1, 0);
    check("t4_slot_zero", 32'({o_opcode, o_operand1, o_operand2}), 32'h0);
    check("t4_ready", 32'(o_instr_ready), 32'h1);
    repeat (3) cyc(0, 16'h0000, 0, 0, 0, 0);
    check("t4_issued_same", 32'(o_issued), 32'(iss));

    // illegal opcode
    cyc(1, 16'h3041, 0, 0, 0, 0);
    check("t5_nop", 32'({o_opcode, o_operand1, o_operand2}), 32'h0);
    check("t5_pulse", 32'(o_illegal), 32'h1);
    cyc(0, 16'h0000, 0, 0, 0, 0);
    check("t5_pulse_end", 32'(o_illegal), 32'h0);
    check("t5_issued_same", 32'(o_issued), 32'(iss));

    // back-to-back stream
    iss = o_issued;
    for (int i = 0; i < 8; i++) begin
      check("t6_ready", 32'(o_instr_ready), 32'h1);
      case (i % 3)
        0:       op = 4'hB;
        1:       op = 4'hD;
        default: op = 4'hF;
      endcase
      w = {op, 12'($urandom)};
      cyc(1, w, 0, 0, 0, 0);
    end
    repeat (2) cyc(0, 16'h0000, 0, 0, 0, 0);
    check("t6_issued", 32'(o_issued), 32'(iss + 16'd8));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 4))
        0:       op = 4'h0;
        1:       op = 4'hB;
        2:       op = 4'hD;
        3:       op = 4'hF;
        default: op = 4'($urandom_range(0, 15));
      endcase
      w = {op, 12'($urandom)};
      cyc($urandom_range(0, 3) != 0, w,
          $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 30) == 0, $urandom_range(0, 400) == 0);
    end
    cyc(0, 16'h0000, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
